// File: rtl/fsm_stim_sequencer_if.sv
// Host, result and detector signals of the stimulus sequencer.
// The slave modport is the sequencer, master is the host, det is the detector.
interface fsm_stim_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int LEN_W = $clog2(WIDTH) + 1,
  parameter int CNT_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             abort;
  logic             res_valid;
  logic             res_ready;
  logic [CNT_W-1:0] res_count;
  logic             det_rst;
  logic             det_din;
  logic             det_dout;

  modport slave (
    input  cmd_valid, cmd_data, cmd_len, abort, res_ready, det_dout,
    output cmd_ready, res_valid, res_count, det_rst, det_din
  );

  modport master (
    output cmd_valid, cmd_data, cmd_len, abort, res_ready,
    input  cmd_ready, res_valid, res_count
  );

  modport det (
    input  det_rst, det_din,
    output det_dout
  );
endinterface

// File: rtl/fsm_stim_sequencer.sv
// Shifts a host pattern LSB-first into the serial detector after a reset
// window, counts detector pulses and returns the count to the host.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for a command, detector held in reset
// ST_RESET | detector held in reset for RST_CYC cycles
// ST_SHIFT | one pattern bit per cycle on det_din, pulses counted
// ST_DRAIN | det_din low for DRAIN_CYC cycles, pulses still counted
// ST_DONE  | result offered to the host, detector back in reset
module fsm_stim_sequencer #(
  parameter int WIDTH     = 16,
  parameter int LEN_W     = $clog2(WIDTH) + 1,
  parameter int RST_CYC   = 2,
  parameter int DRAIN_CYC = 3,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fsm_stim_sequencer_if.slave  bus
);

  localparam int TMR_MAX = (RST_CYC > DRAIN_CYC) ? RST_CYC : DRAIN_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RESET, ST_SHIFT, ST_DRAIN, ST_DONE
  } state_e;

  state_e           state_q;
  logic             cmd_ready_q;
  logic             det_rst_q;
  logic             det_din_q;
  logic             res_valid_q;
  logic [CNT_W-1:0] res_count_q;
  logic [WIDTH-1:0] shreg_q;
  logic [LEN_W-1:0] bits_q;
  logic [TMR_W-1:0] timer_q;

  logic [LEN_W-1:0] len_clamp_d;
  logic [CNT_W-1:0] count_d;
  logic [WIDTH-1:0] shreg_d;
  logic             abortable_d;

  always_comb begin
    len_clamp_d = (bus.cmd_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : bus.cmd_len;
    // Saturating increment: the count sticks at all-ones instead of wrapping.
    count_d     = (bus.det_dout && (res_count_q != '1)) ? res_count_q + CNT_W'(1)
                                                        : res_count_q;
    shreg_d     = shreg_q >> 1;
    abortable_d = (state_q == ST_RESET) || (state_q == ST_SHIFT) || (state_q == ST_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      det_rst_q   <= 1'b1;
      det_din_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_count_q <= '0;
      shreg_q     <= '0;
      bits_q      <= '0;
      timer_q     <= '0;
    end else if (bus.abort && abortable_d) begin
      // Abort takes priority over any transition the state would make.
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      det_rst_q   <= 1'b1;
      det_din_q   <= 1'b0;
      res_count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            state_q     <= ST_RESET;
            cmd_ready_q <= 1'b0;
            shreg_q     <= bus.cmd_data;
            bits_q      <= len_clamp_d;
            res_count_q <= '0;
            timer_q     <= RST_LOAD;
          end
        end
        ST_RESET: begin
          if (timer_q == '0) begin
            det_rst_q <= 1'b0;
            if (bits_q != '0) begin
              state_q   <= ST_SHIFT;
              det_din_q <= shreg_q[0];
            end else begin
              state_q   <= ST_DRAIN;
              det_din_q <= 1'b0;
              timer_q   <= DRAIN_LOAD;
            end
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_SHIFT: begin
          res_count_q <= count_d;
          if (bits_q == LEN_W'(1)) begin
            state_q   <= ST_DRAIN;
            det_din_q <= 1'b0;
            timer_q   <= DRAIN_LOAD;
          end else begin
            bits_q    <= bits_q - LEN_W'(1);
            shreg_q   <= shreg_d;
            det_din_q <= shreg_d[0];
          end
        end
        ST_DRAIN: begin
          res_count_q <= count_d;
          if (timer_q == '0) begin
            state_q     <= ST_DONE;
            det_rst_q   <= 1'b1;
            res_valid_q <= 1'b1;
          end else begin
            timer_q <= timer_q - TMR_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
          det_rst_q   <= 1'b1;
          det_din_q   <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.det_rst   = det_rst_q;
  assign bus.det_din   = det_din_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_count = res_count_q;

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// Directed bench for fsm_stim_sequencer driving a behavioural idle/s0/s1
// detector, plus a narrow-counter instance with det_dout held high.
module tb_fsm_stim_sequencer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  fsm_stim_sequencer_if #(.WIDTH(16), .CNT_W(8)) bus ();
  fsm_stim_sequencer_if #(.WIDTH(16), .CNT_W(3)) bus2 ();

  fsm_stim_sequencer #(.WIDTH(16), .RST_CYC(2), .DRAIN_CYC(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fsm_stim_sequencer #(.WIDTH(16), .RST_CYC(2), .DRAIN_CYC(3), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Team detector: first bit idle->s0, each 1 toggles s0/s1, pulse on s1->s0.
  logic [1:0] det_st;
  always @(posedge clk or posedge bus.det_rst) begin
    if (bus.det_rst) begin
      det_st <= 2'd0;
      bus.det_dout <= 1'b0;
    end else begin
      bus.det_dout <= 1'b0;
      case (det_st)
        2'd0: det_st <= 2'd1;
        2'd1: if (bus.det_din) det_st <= 2'd2;
        default: if (bus.det_din) begin
          det_st <= 2'd1;
          bus.det_dout <= 1'b1;
        end
      endcase
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_cmd(input logic [15:0] d, input logic [4:0] l, output int lat,
                         output logic [7:0] cnt, output logic [31:0] din_tr,
                         output logic [31:0] rst_tr);
    int cyc;
    din_tr = '0; rst_tr = '0; lat = -1; cnt = '0;
    for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b1; bus.cmd_data = d; bus.cmd_len = l;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      if (cyc < 32) begin
        din_tr[cyc] = bus.det_din;
        rst_tr[cyc] = bus.det_rst;
      end
      if (bus.res_valid === 1'b1) begin
        lat = cyc; cnt = bus.res_count;
        break;
      end
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    n_checks++; if (bus.det_rst !== 1'b1) begin n_fail++; $display("FAIL reset_det_rst: got %b want 1", bus.det_rst); end
    n_checks++; if (bus.det_din !== 1'b0) begin n_fail++; $display("FAIL reset_det_din: got %b want 0", bus.det_din); end
    n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    n_checks++; if (bus.res_count !== 8'd0) begin n_fail++; $display("FAIL reset_res_count: got %0d want 0", bus.res_count); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin n_fail++; $display("FAIL post_reset_idle: got %b want 10", {bus.cmd_ready, bus.res_valid}); end
  endtask

  task automatic test_short();
    int lat; logic [7:0] cnt; logic [31:0] dtr; logic [31:0] rtr;
    run_cmd(16'h000F, 5'd4, lat, cnt, dtr, rtr);
    n_checks++; if (lat != 10) begin n_fail++; $display("FAIL short_latency: got %0d want 10", lat); end
    n_checks++; if (cnt !== 8'd1) begin n_fail++; $display("FAIL short_count: got %0d want 1", cnt); end
    n_checks++; if (dtr[9:3] !== 7'b0001111) begin n_fail++; $display("FAIL short_din_seq: got %b want 0001111", dtr[9:3]); end
    n_checks++; if (rtr[3:1] !== 3'b011) begin n_fail++; $display("FAIL short_det_rst: got %b want 011", rtr[3:1]); end
    consume();
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL short_ready_after: got %b want 1", bus.cmd_ready); end
  endtask

  task automatic test_full_hold();
    int lat; logic [7:0] cnt; logic [31:0] dtr; logic [31:0] rtr;
    run_cmd(16'hFFFF, 5'd16, lat, cnt, dtr, rtr);
    n_checks++; if (lat != 22) begin n_fail++; $display("FAIL full_latency: got %0d want 22", lat); end
    n_checks++; if (cnt !== 8'd7) begin n_fail++; $display("FAIL full_count: got %0d want 7", cnt); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bus.res_valid, bus.cmd_ready, bus.res_count} !== {1'b1, 1'b0, 8'd7}) begin
        n_fail++; $display("FAIL hold_stable[%0d]: got v=%b r=%b c=%0d want v=1 r=0 c=7", i, bus.res_valid, bus.cmd_ready, bus.res_count);
      end
      bus.abort = (i == 2);
      @(posedge clk); #1;
    end
    bus.abort = 1'b0;
    n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL done_abort_ignored: got %b want 1", bus.res_valid); end
    consume();
    n_checks++; if ({bus.cmd_ready, bus.res_valid} !== 2'b10) begin n_fail++; $display("FAIL full_handshake: got %b want 10", {bus.cmd_ready, bus.res_valid}); end
  endtask

  task automatic test_len_edges();
    int lat; logic [7:0] cnt; logic [31:0] dtr; logic [31:0] rtr;
    run_cmd(16'hFFFF, 5'd0, lat, cnt, dtr, rtr);
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL len0_latency: got %0d want 6", lat); end
    n_checks++; if (cnt !== 8'd0) begin n_fail++; $display("FAIL len0_count: got %0d want 0", cnt); end
    n_checks++; if (dtr !== 32'd0) begin n_fail++; $display("FAIL len0_din: got %h want 0", dtr); end
    n_checks++; if (rtr[5:1] !== 5'b00011) begin n_fail++; $display("FAIL len0_det_rst: got %b want 00011", rtr[5:1]); end
    consume();
    run_cmd(16'hFFFF, 5'd20, lat, cnt, dtr, rtr);
    n_checks++; if (lat != 22) begin n_fail++; $display("FAIL clamp_latency: got %0d want 22", lat); end
    n_checks++; if (cnt !== 8'd7) begin n_fail++; $display("FAIL clamp_count: got %0d want 7", cnt); end
    consume();
    run_cmd(16'h00AA, 5'd8, lat, cnt, dtr, rtr);
    n_checks++; if (lat != 14) begin n_fail++; $display("FAIL aa_latency: got %0d want 14", lat); end
    n_checks++; if (cnt !== 8'd2) begin n_fail++; $display("FAIL aa_count: got %0d want 2", cnt); end
    consume();
    run_cmd(16'h5555, 5'd16, lat, cnt, dtr, rtr);
    n_checks++; if (cnt !== 8'd3) begin n_fail++; $display("FAIL p5555_count: got %0d want 3", cnt); end
    consume();
  endtask

  task automatic test_abort();
    int lat; logic [7:0] cnt; logic [31:0] dtr; logic [31:0] rtr; bit seen;
    bus.cmd_valid = 1'b1; bus.cmd_data = 16'hFFFF; bus.cmd_len = 5'd16;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    n_checks++; if (bus.res_count !== 8'd1) begin n_fail++; $display("FAIL abort_precount: got %0d want 1", bus.res_count); end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    n_checks++;
    if ({bus.cmd_ready, bus.det_rst, bus.res_valid, bus.res_count} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL abort_idle: got r=%b dr=%b v=%b c=%0d want r=1 dr=1 v=0 c=0", bus.cmd_ready, bus.det_rst, bus.res_valid, bus.res_count);
    end
    seen = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (bus.res_valid === 1'b1) seen = 1'b1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL abort_no_result: got res_valid=1 want none"); end
    run_cmd(16'h000F, 5'd4, lat, cnt, dtr, rtr);
    n_checks++; if (cnt !== 8'd1 || lat != 10) begin n_fail++; $display("FAIL after_abort: got c=%0d lat=%0d want c=1 lat=10", cnt, lat); end
    consume();
    // abort coinciding with the last DRAIN cycle of a len=0 command
    bus.cmd_valid = 1'b1; bus.cmd_data = 16'h0000; bus.cmd_len = 5'd0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    n_checks++; if ({bus.res_valid, bus.cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL abort_wins: got v/r=%b want 01", {bus.res_valid, bus.cmd_ready}); end
    // abort during IDLE must not block the accept
    bus.abort = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_data = 16'h000F; bus.cmd_len = 5'd4;
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.cmd_valid = 1'b0;
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL idle_abort_accept: got cmd_ready=%b want 0", bus.cmd_ready); end
    lat = -1;
    for (int i = 1; i < 40; i++) begin
      if (bus.res_valid === 1'b1) begin lat = i; break; end
      @(posedge clk); #1;
    end
    n_checks++; if (lat != 10 || bus.res_count !== 8'd1) begin n_fail++; $display("FAIL idle_abort_result: got lat=%0d c=%0d want lat=10 c=1", lat, bus.res_count); end
    consume();
  endtask

  task automatic test_async_rst();
    int lat; logic [7:0] cnt; logic [31:0] dtr; logic [31:0] rtr;
    bus.cmd_valid = 1'b1; bus.cmd_data = 16'hFFFF; bus.cmd_len = 5'd16;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    n_checks++; if ({bus.det_rst, bus.det_din} !== 2'b01) begin n_fail++; $display("FAIL pre_rst_shift: got %b want 01", {bus.det_rst, bus.det_din}); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.cmd_ready, bus.det_rst, bus.det_din, bus.res_valid, bus.res_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_fail++; $display("FAIL async_rst: got r=%b dr=%b d=%b v=%b c=%0d want 1 1 0 0 0", bus.cmd_ready, bus.det_rst, bus.det_din, bus.res_valid, bus.res_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    run_cmd(16'h000F, 5'd4, lat, cnt, dtr, rtr);
    n_checks++; if (cnt !== 8'd1 || lat != 10) begin n_fail++; $display("FAIL after_rst: got c=%0d lat=%0d want c=1 lat=10", cnt, lat); end
    consume();
  endtask

  task automatic test_saturation();
    logic [4:0] lens [2];
    logic [2:0] want [2];
    int lat;
    lens[0] = 5'd0; want[0] = 3'd3;
    lens[1] = 5'd5; want[1] = 3'd7;
    for (int k = 0; k < 2; k++) begin
      bus2.cmd_valid = 1'b1; bus2.cmd_data = 16'hFFFF; bus2.cmd_len = lens[k];
      @(posedge clk); #1;
      bus2.cmd_valid = 1'b0;
      lat = -1;
      for (int i = 1; i < 40; i++) begin
        if (bus2.res_valid === 1'b1) begin lat = i; break; end
        @(posedge clk); #1;
      end
      n_checks++;
      if (lat < 0 || bus2.res_count !== want[k]) begin
        n_fail++; $display("FAIL sat_count[%0d]: got c=%0d lat=%0d want c=%0d", k, bus2.res_count, lat, want[k]);
      end
      bus2.res_ready = 1'b1;
      @(posedge clk); #1;
      bus2.res_ready = 1'b0;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_data = '0; bus.cmd_len = '0; bus.abort = 1'b0; bus.res_ready = 1'b0;
    bus2.cmd_valid = 1'b0; bus2.cmd_data = '0; bus2.cmd_len = '0; bus2.abort = 1'b0; bus2.res_ready = 1'b0;
    bus2.det_dout = 1'b1;
    #1;
    test_reset();
    test_short();
    test_full_hold();
    test_len_edges();
    test_abort();
    test_async_rst();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
